fetch_sequencer: RTL and testbench

- Multi-cycle instruction fetch and control sequencer for the 8-bit CPU.
- Drives `rom_address` and latches the 2-byte instruction (`rom_data1`/`rom_data2`) into an instruction register.
- Decodes the instruction and issues per-phase control strobes to the register file, ALU and data RAM.
- Sits between ROM and CPU datapath, replacing bench-driven `opcode1`/`opcode2`.

---
 rtl/cpu_pkg.sv | 46 ++++
 rtl/instr_decoder.sv | 40 ++++
 rtl/fetch_sequencer.sv | 246 ++++++++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module  : cpu_pkg
// Purpose : Shared opcode, sequencer-state and write-select types for the CPU.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int INSTR_BYTES = 2;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDI = 4'h1,
        OP_LD  = 4'h2,
        OP_ST  = 4'h3,
        OP_JMP = 4'h4,
        OP_ALU = 4'h8,
        OP_HLT = 4'hF
    } op_e;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } seq_state_e;

    typedef enum logic [1:0] {
        WSEL_IMM = 2'd0,
        WSEL_MEM = 2'd1,
        WSEL_ALU = 2'd2
    } wsel_e;

    function automatic logic op_is_legal(input logic [3:0] op);
        case (op)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'hF: op_is_legal = 1'b1;
            default:                                 op_is_legal = 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/instr_decoder.sv
// ============================================================================
// Module  : instr_decoder
// Purpose : Combinational split of the 16-bit IR into op class and fields.
//           Optional ILLEGAL_TRAP_EN exposes the illegal-opcode flag.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_decoder
    import cpu_pkg::*;
(
    input  logic [15:0] i_ir,
    output op_e         o_op,
    output logic [3:0]  o_r,
    output logic [3:0]  o_rb,
    output logic [3:0]  o_rdst,
    output logic [7:0]  o_imm
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic        o_illegal
`endif
);

    logic w_legal;

    assign w_legal = op_is_legal(i_ir[15:12]);
    // Unknown opcodes collapse to NOP so the sequencer never sees them.
    assign o_op    = w_legal ? op_e'(i_ir[15:12]) : OP_NOP;
    assign o_r     = i_ir[11:8];
    assign o_imm   = i_ir[7:0];
    assign o_rb    = i_ir[7:4];
    assign o_rdst  = i_ir[3:0];

`ifdef ILLEGAL_TRAP_EN
    assign o_illegal = ~w_legal;
`endif

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module  : fetch_sequencer
// Purpose : Multi-cycle fetch/decode/execute control sequencer for the 8-bit
//           CPU. Optional ILLEGAL_TRAP_EN halts on illegal ops (sticky flag).
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter int         PC_STEP  = INSTR_BYTES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rom_data1,
    input  logic [7:0] rom_data2,
    input  logic       mem_ready,
    output logic [7:0] rom_address,
    output logic [7:0] opcode1,
    output logic [7:0] opcode2,
    output logic       reg_we,
    output logic [3:0] reg_waddr,
    output logic [1:0] reg_wsel,
    output logic       alu_en,
    output logic [3:0] alu_ra,
    output logic [3:0] alu_rb,
    output logic       mem_re,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic       instr_done,
    output logic       halted
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic       illegal
`endif
);

    seq_state_e r_state, w_state_nxt;
    logic [7:0]  r_pc, w_pc_nxt;
    logic [15:0] r_ir, w_ir_nxt;
    logic        r_reg_we, w_reg_we;
    logic [3:0]  r_reg_waddr, w_reg_waddr;
    wsel_e       r_reg_wsel, w_reg_wsel;
    logic        r_alu_en, w_alu_en;
    logic [3:0]  r_alu_ra, w_alu_ra;
    logic [3:0]  r_alu_rb, w_alu_rb;
    logic        r_mem_re, w_mem_re;
    logic        r_mem_we, w_mem_we;
    logic [7:0]  r_mem_addr, w_mem_addr;
    logic        r_halted, w_halted;
    logic        w_done;

    op_e        w_op;
    logic [3:0] w_r, w_rb, w_rdst;
    logic [7:0] w_imm;

`ifdef ILLEGAL_TRAP_EN
    logic w_illegal, w_illegal_set, r_illegal;
`endif

    instr_decoder u_dec (
        .i_ir      (r_ir),
        .o_op      (w_op),
        .o_r       (w_r),
        .o_rb      (w_rb),
        .o_rdst    (w_rdst),
        .o_imm     (w_imm)
`ifdef ILLEGAL_TRAP_EN
        ,
        .o_illegal (w_illegal)
`endif
    );

    // Strobe registers are loaded with the values of the state being entered.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_reg_we    = 1'b0;
        w_reg_waddr = 4'h0;
        w_reg_wsel  = WSEL_IMM;
        w_alu_en    = 1'b0;
        w_alu_ra    = 4'h0;
        w_alu_rb    = 4'h0;
        w_mem_re    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = 8'h00;
        w_halted    = 1'b0;
        w_done      = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        w_illegal_set = 1'b0;
`endif
        case (r_state)
            S_FETCH: begin
                w_ir_nxt    = {rom_data1, rom_data2};
                w_pc_nxt    = r_pc + 8'(PC_STEP);
                w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                case (w_op)
                    OP_LDI: begin
                        w_state_nxt = S_WB;
                        w_reg_we    = 1'b1;
                        w_reg_waddr = w_r;
                        w_reg_wsel  = WSEL_IMM;
                    end
                    OP_LD: begin
                        w_state_nxt = S_MEM;
                        w_mem_re    = 1'b1;
                        w_mem_addr  = w_imm;
                    end
                    OP_ST: begin
                        w_state_nxt = S_MEM;
                        w_mem_we    = 1'b1;
                        w_mem_addr  = w_imm;
                        w_reg_waddr = w_r;
                    end
                    OP_ALU: begin
                        w_state_nxt = S_EXEC;
                        w_alu_en    = 1'b1;
                        w_alu_ra    = w_r;
                        w_alu_rb    = w_rb;
                    end
                    OP_JMP: begin
                        w_state_nxt = S_FETCH;
                        w_pc_nxt    = w_imm;
                        w_done      = 1'b1;
                    end
                    OP_HLT: begin
                        w_state_nxt = S_HALT;
                        w_halted    = 1'b1;
                    end
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        if (w_illegal) begin
                            w_state_nxt   = S_HALT;
                            w_halted      = 1'b1;
                            w_illegal_set = 1'b1;
                        end else
`endif
                        begin
                            w_state_nxt = S_FETCH;
                            w_done      = 1'b1;
                        end
                    end
                endcase
            end
            S_EXEC: begin
                w_state_nxt = S_WB;
                w_reg_we    = 1'b1;
                w_reg_waddr = w_rdst;
                w_reg_wsel  = WSEL_ALU;
            end
            S_MEM: begin
                if (mem_ready && (w_op == OP_LD)) begin
                    w_state_nxt = S_WB;
                    w_reg_we    = 1'b1;
                    w_reg_waddr = w_r;
                    w_reg_wsel  = WSEL_MEM;
                end else if (mem_ready) begin
                    w_state_nxt = S_FETCH;
                    w_done      = 1'b1;
                end else begin
                    w_mem_re    = (w_op == OP_LD);
                    w_mem_we    = (w_op == OP_ST);
                    w_mem_addr  = w_imm;
                    w_reg_waddr = (w_op == OP_ST) ? w_r : 4'h0;
                end
            end
            S_WB: begin
                w_state_nxt = S_FETCH;
                w_done      = 1'b1;
            end
            S_HALT: begin
                w_halted = 1'b1;
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_PC;
            r_ir        <= 16'h0000;
            r_reg_we    <= 1'b0;
            r_reg_waddr <= 4'h0;
            r_reg_wsel  <= WSEL_IMM;
            r_alu_en    <= 1'b0;
            r_alu_ra    <= 4'h0;
            r_alu_rb    <= 4'h0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 8'h00;
            r_halted    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_ir        <= w_ir_nxt;
            r_reg_we    <= w_reg_we;
            r_reg_waddr <= w_reg_waddr;
            r_reg_wsel  <= w_reg_wsel;
            r_alu_en    <= w_alu_en;
            r_alu_ra    <= w_alu_ra;
            r_alu_rb    <= w_alu_rb;
            r_mem_re    <= w_mem_re;
            r_mem_we    <= w_mem_we;
            r_mem_addr  <= w_mem_addr;
            r_halted    <= w_halted;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= r_illegal | w_illegal_set;
        end
    end
    assign illegal = r_illegal;
`endif

    assign rom_address = r_pc;
    assign opcode1     = r_ir[15:8];
    assign opcode2     = r_ir[7:0];
    assign reg_we      = r_reg_we;
    assign reg_waddr   = r_reg_waddr;
    assign reg_wsel    = r_reg_wsel;
    assign alu_en      = r_alu_en;
    assign alu_ra      = r_alu_ra;
    assign alu_rb      = r_alu_rb;
    assign mem_re      = r_mem_re;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign halted      = r_halted;
    // Completion depends on mem_ready in MEM, so it cannot be pre-registered.
    assign instr_done  = w_done;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// Module  : tb_fetch_sequencer
// Purpose : Self-checking bench; per-instruction cycle model from the ISA rules.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_sequencer;

    typedef struct packed {
        logic [7:0] pc;
        logic       we;
        logic [3:0] wa;
        logic [1:0] ws;
        logic       ae;
        logic [3:0] ra;
        logic [3:0] rb;
        logic       re;
        logic       mw;
        logic [7:0] ma;
        logic       done;
        logic       hlt;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       mem_ready;
    logic [7:0] rom_data1, rom_data2, rom_address, opcode1, opcode2, mem_addr;
    logic       reg_we, alu_en, mem_re, mem_we, instr_done, halted;
    logic [3:0] reg_waddr, alu_ra, alu_rb;
    logic [1:0] reg_wsel;
    logic [7:0] w_a1;
`ifdef ILLEGAL_TRAP_EN
    logic       illegal;
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic [7:0] rom [256];
    logic [7:0] m_pc;
    bit         m_halted;
    int         n_checks = 0;
    int         n_err    = 0;

    assign w_a1      = rom_address + 8'd1;
    assign rom_data1 = rom[rom_address];
    assign rom_data2 = rom[w_a1];

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .rom_data1   (rom_data1),
        .rom_data2   (rom_data2),
        .mem_ready   (mem_ready),
        .rom_address (rom_address),
        .opcode1     (opcode1),
        .opcode2     (opcode2),
        .reg_we      (reg_we),
        .reg_waddr   (reg_waddr),
        .reg_wsel    (reg_wsel),
        .alu_en      (alu_en),
        .alu_ra      (alu_ra),
        .alu_rb      (alu_rb),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .instr_done  (instr_done),
        .halted      (halted)
`ifdef ILLEGAL_TRAP_EN
        ,
        .illegal     (illegal)
`endif
    );

    function automatic obs_t observe();
        obs_t o;
        o.pc = rom_address; o.we = reg_we; o.wa = reg_waddr; o.ws = reg_wsel;
        o.ae = alu_en; o.ra = alu_ra; o.rb = alu_rb; o.re = mem_re; o.mw = mem_we;
        o.ma = mem_addr; o.done = instr_done; o.hlt = halted;
        return o;
    endfunction

    function automatic obs_t idle(input logic [7:0] pc);
        obs_t o;
        o = '0;
        o.pc = pc;
        return o;
    endfunction

    task automatic chk_obs(input string tag, input obs_t exp);
        obs_t got;
        got = observe();
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h (pc/we/wa/ws/ae/ra/rb/re/mw/ma/done/hlt)", tag, got, exp);
        end
    endtask

    task automatic chk_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle(input logic rdy);
        @(posedge clk);
        #2 mem_ready = rdy;
        #1;
    endtask

    task automatic do_reset_now();
        reset = 1'b0;
        #1;
        chk_obs("async_reset", idle(8'h00));
        chk_val("ir_reset", {opcode1, opcode2}, 16'h0000);
        @(posedge clk);
        #2 reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        m_pc     = 8'h00;
        m_halted = 1'b0;
    endtask

    // Entered at the check point of the FETCH cycle; leaves at the next FETCH.
    task automatic do_instr(input logic [7:0] b1, input logic [7:0] b2, input int wait_n);
        logic [3:0] op;
        logic [3:0] r;
        logic [7:0] pcn;
        bit         legal;
        obs_t       e;
        op    = b1[7:4];
        r     = b1[3:0];
        pcn   = m_pc + 8'd2;
        legal = op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'hF};
        rom[m_pc]         = b1;
        rom[m_pc + 8'd1]  = b2;
        chk_obs("fetch", idle(m_pc));
        next_cycle(1'b1);
        e = idle(pcn);
        e.done = (op == 4'h0) || (op == 4'h4) || (!legal && !TRAP);
        chk_obs("decode", e);
        chk_val("ir", {opcode1, opcode2}, {b1, b2});
        if (op == 4'hF || (!legal && TRAP)) begin
            for (int i = 0; i < 20; i++) begin
                next_cycle(1'b1);
                e = idle(pcn);
                e.hlt = 1'b1;
                chk_obs("halt", e);
            end
`ifdef ILLEGAL_TRAP_EN
            chk_val("illegal_flag", {15'h0, illegal}, {15'h0, !legal});
`endif
            m_pc     = pcn;
            m_halted = 1'b1;
            return;
        end
        case (op)
            4'h1: begin
                next_cycle(1'b1);
                e = idle(pcn); e.we = 1'b1; e.wa = r; e.ws = 2'd0; e.done = 1'b1;
                chk_obs("wb_ldi", e);
            end
            4'h8: begin
                next_cycle(1'b1);
                e = idle(pcn); e.ae = 1'b1; e.ra = r; e.rb = b2[7:4];
                chk_obs("exec_alu", e);
                next_cycle(1'b1);
                e = idle(pcn); e.we = 1'b1; e.wa = b2[3:0]; e.ws = 2'd2; e.done = 1'b1;
                chk_obs("wb_alu", e);
            end
            4'h2, 4'h3: begin
                for (int i = 0; i <= wait_n; i++) begin
                    next_cycle(i == wait_n);
                    e = idle(pcn);
                    e.re = (op == 4'h2); e.mw = (op == 4'h3); e.ma = b2;
                    e.wa = (op == 4'h3) ? r : 4'h0;
                    e.done = (op == 4'h3) && (i == wait_n);
                    chk_obs("mem", e);
                end
                if (op == 4'h2) begin
                    next_cycle(1'b1);
                    e = idle(pcn); e.we = 1'b1; e.wa = r; e.ws = 2'd1; e.done = 1'b1;
                    chk_obs("wb_ld", e);
                end
            end
            default: ;
        endcase
        m_pc = (op == 4'h4) ? b2 : pcn;
        next_cycle(1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] ops [8];
        logic [3:0] op;
        obs_t       e;
        int         n_ops;
        ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h5, 4'hC};
        n_ops = TRAP ? 6 : 8;
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        reset     = 1'b0;
        mem_ready = 1'b1;
        m_halted  = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk_obs("reset_state", idle(8'h00));
        chk_val("ir_reset_state", {opcode1, opcode2}, 16'h0000);
        reset = 1'b1;
        #1;
        m_pc = 8'h00;

        do_instr(8'h10, 8'hFF, 0);
        do_instr(8'h80, 8'h13, 0);
        do_instr(8'h33, 8'h82, 3);
        do_instr(8'h2A, 8'h44, 2);
        do_instr(8'h40, 8'hFE, 0);
        do_instr(8'h40, 8'h10, 0);
        do_instr(8'h40, 8'hFE, 0);
        do_instr(8'h00, 8'h00, 0);
        do_instr(8'h40, 8'hFF, 0);
        do_instr(8'h00, 8'h00, 0);
        chk_val("odd_pc_wrap", {8'h00, rom_address}, 16'h0001);

        for (int k = 0; k < 150; k++) begin
            op = ops[$urandom_range(0, n_ops - 1)];
            do_instr({op, 4'($urandom)}, 8'($urandom), $urandom_range(0, 3));
        end

        // Abort a load while it is stalled in the memory phase.
        rom[m_pc]        = 8'h27;
        rom[m_pc + 8'd1] = 8'h55;
        chk_obs("abort_fetch", idle(m_pc));
        next_cycle(1'b1);
        next_cycle(1'b0);
        e = idle(m_pc + 8'd2); e.re = 1'b1; e.ma = 8'h55;
        chk_obs("abort_mem", e);
        do_reset_now();
        do_instr(8'h12, 8'h34, 0);

        do_instr(8'h50, 8'h00, 0);
        if (m_halted) do_reset_now();

        do_instr(8'hF0, 8'h00, 0);
        do_reset_now();
        chk_obs("post_halt_fetch", idle(8'h00));
        do_instr(8'h00, 8'h00, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
